// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: definitions shared by the UART transmitter files.
//   UART_DATA_BITS : data bits per frame
//   tx_state_e     : transmitter FSM states
//   clks_per_bit() : baud divider, the same expression the receiver uses
//   is_pow2()      : FIFO depth legality helper
package uart_tx_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-producer side of the UART transmitter.
//   tx_data/tx_data_valid : byte offered by the producer
//   tx_ready              : transmitter FIFO can take a byte this cycle
//   tx_serial             : UART line (idle high)
//   tx_busy               : frame in flight or bytes still queued
//   tx_fifo_level         : bytes currently queued
// master = producer, slave = uart_tx.
interface uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    import uart_tx_pkg::*;

    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_data_valid;
    logic                      tx_ready;
    logic                      tx_serial;
    logic                      tx_busy;
    logic [LEVEL_W-1:0]        tx_fifo_level;

    modport master (
        output tx_data, tx_data_valid,
        input  tx_ready, tx_serial, tx_busy, tx_fifo_level
    );

    modport slave (
        input  tx_data, tx_data_valid,
        output tx_ready, tx_serial, tx_busy, tx_fifo_level
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock synchronous FIFO with first-word fall-through read.
//   clk, rst : clock and synchronous active-high reset (flushes the FIFO)
//   wr_en/din: write request; ignored while full, even if a read happens too
//   rd_en    : pop request; ignored while empty
//   dout     : head entry, valid whenever empty is low
//   full, empty, level : occupancy derived from the registered level
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LEVEL_W-1:0] level_r;
    logic               do_wr_s;
    logic               do_rd_s;

    assign full    = (level_r == FULL_LEVEL);
    assign empty   = (level_r == {LEVEL_W{1'b0}});
    assign level   = level_r;
    assign dout    = mem_r[rd_ptr_r];
    assign do_wr_s = wr_en && !full;
    assign do_rd_s = rd_en && !empty;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LEVEL_W{1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   level_r <= level_r + LEVEL_W'(1);
                2'b01:   level_r <= level_r - LEVEL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8 data bits, no parity, STOP_BITS stop bits, LSB first.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset; abandons any frame in flight
//   bus : uart_tx_if.slave - byte handshake in, serial line and status out
// Bytes are queued in uart_tx_fifo and sent back-to-back with no idle gap.
// The line is a flop driven from the current FSM state, so it lags the state
// by one cycle: a byte written into an empty FIFO appears as a falling edge
// two clocks after it was accepted.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 9600,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(STOP_CLKS);
    localparam int LEVEL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

    if ((CLKS_PER_BIT < 2) || !((STOP_BITS == 1) || (STOP_BITS == 2)) || !is_pow2(FIFO_DEPTH)) begin : g_param_check
        $error("uart_tx: need CLKS_PER_BIT >= 2, STOP_BITS in {1,2}, FIFO_DEPTH a power of two >= 2");
    end

    tx_state_e                 state_r;
    tx_state_e                 state_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_s;
    logic [2:0]                bit_idx_r;
    logic [2:0]                bit_idx_s;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [UART_DATA_BITS-1:0] shift_s;
    logic                      pop_s;
    logic                      line_s;
    logic                      tx_serial_r;
    logic                      tx_busy_r;
    logic [UART_DATA_BITS-1:0] fifo_dout_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic [LEVEL_W-1:0]        fifo_level_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (bus.tx_data_valid),
        .din   (bus.tx_data),
        .rd_en (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    assign bus.tx_ready      = !fifo_full_s;
    assign bus.tx_fifo_level = fifo_level_s;
    assign bus.tx_serial     = tx_serial_r;
    assign bus.tx_busy       = tx_busy_r;

    // Next-state logic: frame sequencing, baud counting and FIFO pops.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s     = {CNT_W{1'b0}};
                bit_idx_s = 3'd0;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = fifo_dout_s;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s     = {CNT_W{1'b0}};
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s   = {CNT_W{1'b0}};
                    shift_s = {1'b0, shift_r[UART_DATA_BITS-1:1]};
                    if (bit_idx_r == LAST_IDX) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_r == STOP_LAST) begin
                    cnt_s = {CNT_W{1'b0}};
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_s = fifo_dout_s;
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Line level implied by the current state.
    always_comb begin
        line_s = 1'b1;
        case (state_r)
            ST_START: line_s = 1'b0;
            ST_DATA:  line_s = shift_r[0];
            default:  line_s = 1'b1;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            bit_idx_r   <= 3'd0;
            shift_r     <= {UART_DATA_BITS{1'b0}};
            tx_serial_r <= 1'b1;
            tx_busy_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_idx_r   <= bit_idx_s;
            shift_r     <= shift_s;
            tx_serial_r <= line_s;
            tx_busy_r   <= (state_r != ST_IDLE) || (fifo_level_s != {LEVEL_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Two DUTs share clock, reset and byte inputs: dut1 with one stop bit, dut2
// with two. Line and busy of both are recorded per clock edge; expected frames
// are built from the frame definition (start 0, data LSB first, stop 1s, each
// slot CPB clocks) and compared at the predicted edge positions.
module tb_uart_tx;

    localparam int CLK_FREQ_HZ = 80;
    localparam int BAUD_RATE   = 10;
    localparam int FIFO_DEPTH  = 16;
    localparam int CPB         = CLK_FREQ_HZ / BAUD_RATE;
    localparam int LEVEL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int MAX_EDGES   = 8192;

    typedef logic [7:0] byte_q_t[$];

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [7:0] drv_data  = 8'h00;
    logic       drv_valid = 1'b0;
    int         edge_cnt  = 0;
    int         n_checks  = 0;
    int         n_fail    = 0;

    logic tr1 [MAX_EDGES];
    logic tr2 [MAX_EDGES];
    logic bz1 [MAX_EDGES];
    logic bz2 [MAX_EDGES];

    always #5 clk = ~clk;

    uart_tx_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus1 ();
    uart_tx_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus2 ();

    assign bus1.tx_data       = drv_data;
    assign bus1.tx_data_valid = drv_valid;
    assign bus2.tx_data       = drv_data;
    assign bus2.tx_data_valid = drv_valid;

    uart_tx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE), .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_tx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE), .STOP_BITS(2), .FIFO_DEPTH(FIFO_DEPTH))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Edge counter: at a falling edge, edge_cnt is the index of the last rising edge.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Record DUT outputs as they stand after each rising edge.
    always @(negedge clk) begin
        if (edge_cnt < MAX_EDGES) begin
            tr1[edge_cnt] <= bus1.tx_serial;
            tr2[edge_cnt] <= bus2.tx_serial;
            bz1[edge_cnt] <= bus1.tx_busy;
            bz2[edge_cnt] <= bus2.tx_busy;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached at edge %0d, required finish before it", edge_cnt);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic tr(input int sel, input int idx);
        if ((idx < 0) || (idx >= MAX_EDGES)) return 1'bx;
        return (sel == 2) ? tr2[idx] : tr1[idx];
    endfunction

    function automatic logic bt(input int sel, input int idx);
        if ((idx < 0) || (idx >= MAX_EDGES)) return 1'bx;
        return (sel == 2) ? bz2[idx] : bz1[idx];
    endfunction

    // Reference line value i clocks into the frame of byte d.
    function automatic logic model_bit(input logic [7:0] d, input int i);
        int slot;
        slot = i / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        return 1'b1;
    endfunction

    task automatic wait_edges(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        drv_valid = 1'b0;
        rst       = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            check("reset_state", {bus1.tx_serial, bus1.tx_ready, bus1.tx_busy, bus1.tx_fifo_level},
                  {1'b1, 1'b1, 1'b0, {LEVEL_W{1'b0}}});
            check("reset_state_dut2", {bus2.tx_serial, bus2.tx_busy}, 2'b10);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_state", {bus1.tx_serial, bus1.tx_ready, bus1.tx_busy, bus1.tx_fifo_level},
              {1'b1, 1'b1, 1'b0, {LEVEL_W{1'b0}}});
    endtask

    // Offer bytes on consecutive cycles; first_edge is the edge taking the first one.
    task automatic write_bytes(input byte_q_t bytes, output int first_edge);
        first_edge = edge_cnt + 1;
        foreach (bytes[i]) begin
            drv_data  = bytes[i];
            drv_valid = 1'b1;
            @(negedge clk);
        end
        drv_valid = 1'b0;
    endtask

    // Frames for exp must start at edge s and follow each other with no gap.
    task automatic check_stream(input int sel, input int s, input byte_q_t exp, input int sb);
        int         flen;
        int         last;
        int         fs;
        int         mism;
        logic [7:0] got;
        logic       ferr;
        flen = (9 + sb) * CPB;
        last = s + exp.size() * flen;
        wait_edges(last + CPB + 2);
        check("idle_before_start", tr(sel, s - 1), 1'b1);
        foreach (exp[k]) begin
            fs   = s + k * flen;
            mism = 0;
            for (int i = 0; i < flen; i++) begin
                if (tr(sel, fs + i) !== model_bit(exp[k], i)) mism++;
            end
            check($sformatf("frame%0d_shape_mismatches", k), mism, 0);
            got = 8'h00;
            for (int b = 0; b < 8; b++) got[b] = tr(sel, fs + (1 + b) * CPB + CPB / 2);
            ferr = 1'b0;
            for (int j = 0; j < sb; j++) begin
                if (tr(sel, fs + (9 + j) * CPB + CPB / 2) !== 1'b1) ferr = 1'b1;
            end
            check($sformatf("frame%0d_rx_byte", k), got, exp[k]);
            check($sformatf("frame%0d_framing_error", k), ferr, 1'b0);
        end
        check("busy_drop", {bt(sel, last - 1), bt(sel, last)}, 2'b10);
        mism = 0;
        for (int i = 0; i < CPB; i++) begin
            if (tr(sel, last + i) !== 1'b1) mism++;
        end
        check("line_idle_after_stream", mism, 0);
    endtask

    initial begin
        byte_q_t    q;
        int         n;
        int         s;
        int         c;
        int         nb;
        int         mism;
        int         exp_lvl;
        logic [7:0] v;

        do_reset(10);

        // Single byte.
        q = '{8'h55};
        write_bytes(q, n);
        check_stream(1, n + 2, q, 1);

        // Three-byte burst on consecutive cycles.
        q = '{8'h55, 8'hA3, 8'hF0};
        write_bytes(q, n);
        check_stream(1, n + 2, q, 1);

        // Valid held for 20 cycles: 16 queued plus 1 in the shifter are accepted.
        n = edge_cnt + 1;
        for (int k = 0; k < 20; k++) begin
            exp_lvl = (k == 0) ? 0 : (k == 1) ? 1 : ((k - 1) > 16 ? 16 : k - 1);
            check($sformatf("full_ready_%0d", k), bus1.tx_ready, (k <= 16) ? 32'd1 : 32'd0);
            check($sformatf("full_level_%0d", k), bus1.tx_fifo_level, exp_lvl);
            drv_data  = 8'(k);
            drv_valid = 1'b1;
            @(negedge clk);
        end
        drv_valid = 1'b0;
        q = {};
        for (int k = 0; k <= 16; k++) q.push_back(8'(k));
        check_stream(1, n + 2, q, 1);

        // Random bursts into an idle transmitter.
        for (int r = 0; r < 2; r++) begin
            nb = int'($urandom_range(16, 2));
            q  = {};
            n  = edge_cnt + 1;
            for (int i = 0; i < nb; i++) begin
                v = 8'($urandom);
                q.push_back(v);
                check("rand_ready", bus1.tx_ready, 1'b1);
                drv_data  = v;
                drv_valid = 1'b1;
                @(negedge clk);
            end
            drv_valid = 1'b0;
            check("rand_level", bus1.tx_fifo_level, nb - 1);
            check_stream(1, n + 2, q, 1);
        end

        // Reset during data bit 3 of 0xA3 with a second byte still queued.
        q = '{8'hA3, 8'h5A};
        write_bytes(q, n);
        s = n + 2;
        c = s + 4 * CPB + 2;
        wait_edges(c);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_line", {tr(1, c), bus1.tx_serial}, 2'b01);
        check("midreset_level", bus1.tx_fifo_level, {LEVEL_W{1'b0}});
        check("midreset_busy", bus1.tx_busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_edges(c + 1 + 20 * CPB + 1);
        mism = 0;
        for (int i = c + 1; i <= c + 1 + 20 * CPB; i++) begin
            if (tr(1, i) !== 1'b1) mism++;
        end
        check("no_frame_after_reset", mism, 0);
        q = '{8'hF0};
        write_bytes(q, n);
        check_stream(1, n + 2, q, 1);

        // Two stop bits: stop period is two bit times, next start not earlier.
        do_reset(3);
        q = '{8'h0F, 8'h3C};
        write_bytes(q, n);
        check_stream(2, n + 2, q, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
